// File: rtl/uart_pkg.sv
// Shared UART definitions: one-hot state encoding, parity modes and the parity helper.
// Used by both the transmitter and the receiver so their frame formats stay identical.
package uart_pkg;

  typedef enum logic [4:0] {
    S_IDLE   = 5'b00001,
    S_START  = 5'b00010,
    S_DATA   = 5'b00100,
    S_PARITY = 5'b01000,
    S_STOP   = 5'b10000
  } state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // Caller passes data already masked to the active data bits.
  function automatic logic calc_parity(input logic [7:0] data, input int mode);
    logic p;
    case (mode)
      PARITY_EVEN: p = ^data;
      PARITY_ODD:  p = ~(^data);
      default:     p = 1'b0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1, flags the last count, and
// reloads to zero whenever the owning state machine changes state.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic bit_tick
);

  localparam int            CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_r;

  // Free-running bit-period counter with synchronous restart
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (restart) begin
      cnt_r <= '0;
    end else if (cnt_r == LAST) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

  assign bit_tick = (cnt_r == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: accepts a byte per valid/ready handshake and serialises it
// as start, LSB-first data, optional parity and stop bit(s) on a registered tx line.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  localparam logic [7:0] DATA_MASK = 8'hFF >> (8 - DATA_BITS);
  localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  state_t     state_r;
  state_t     next_state_s;
  logic [7:0] shift_r;
  logic       parity_r;
  logic [2:0] bit_cnt_r;
  logic       tx_r;
  logic       tx_ready_r;
  logic       busy_r;
  logic       tx_done_r;
  logic       tx_s;
  logic       bit_tick_s;
  logic       restart_s;
  logic       accept_s;

  assign accept_s  = tx_valid && tx_ready_r && (state_r == S_IDLE);
  assign restart_s = (next_state_s != state_r);

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (restart_s),
    .bit_tick(bit_tick_s)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; any non-one-hot encoding falls back to idle
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) next_state_s = S_START;
        else          next_state_s = S_IDLE;
      end
      S_START: begin
        if (bit_tick_s) next_state_s = S_DATA;
        else            next_state_s = S_START;
      end
      S_DATA: begin
        if (bit_tick_s && (bit_cnt_r == LAST_DATA)) begin
          if (PARITY != PARITY_NONE) next_state_s = S_PARITY;
          else                       next_state_s = S_STOP;
        end else begin
          next_state_s = S_DATA;
        end
      end
      S_PARITY: begin
        if (bit_tick_s) next_state_s = S_STOP;
        else            next_state_s = S_PARITY;
      end
      S_STOP: begin
        if (bit_tick_s && (bit_cnt_r == LAST_STOP)) next_state_s = S_IDLE;
        else                                        next_state_s = S_STOP;
      end
      default: next_state_s = S_IDLE;
    endcase
  end

  // Shift register, parity latch and data/stop bit counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_r   <= 8'h00;
      parity_r  <= 1'b0;
      bit_cnt_r <= 3'd0;
    end else begin
      if (accept_s) begin
        shift_r  <= tx_data & DATA_MASK;
        parity_r <= calc_parity(tx_data & DATA_MASK, PARITY);
      end else if ((state_r == S_DATA) && bit_tick_s) begin
        shift_r <= {1'b0, shift_r[7:1]};
      end
      if (restart_s) begin
        bit_cnt_r <= 3'd0;
      end else if (bit_tick_s && ((state_r == S_DATA) || (state_r == S_STOP))) begin
        bit_cnt_r <= bit_cnt_r + 3'd1;
      end
    end
  end

  // Line level for the current state
  always_comb begin
    tx_s = 1'b1;
    case (state_r)
      S_IDLE:   tx_s = 1'b1;
      S_START:  tx_s = 1'b0;
      S_DATA:   tx_s = shift_r[0];
      S_PARITY: tx_s = parity_r;
      S_STOP:   tx_s = 1'b1;
      default:  tx_s = 1'b1;
    endcase
  end

  // Registered outputs; tx and busy trail the state by one cycle, so the
  // done pulse lands in the final stop-bit cycle as seen on the line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_r       <= 1'b1;
      tx_ready_r <= 1'b1;
      busy_r     <= 1'b0;
      tx_done_r  <= 1'b0;
    end else begin
      tx_r       <= tx_s;
      tx_ready_r <= (next_state_s == S_IDLE);
      busy_r     <= (state_r != S_IDLE);
      tx_done_r  <= (state_r == S_STOP) && (next_state_s == S_IDLE);
    end
  end

  assign tx       = tx_r;
  assign tx_ready = tx_ready_r;
  assign busy     = busy_r;
  assign tx_done  = tx_done_r;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at CLKS_PER_BIT=4: four instances cover 8N1,
// even parity, odd parity and 7 data bits with 2 stop bits.
module tb_uart_tx;

  localparam int CPB = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [3:0][7:0] tx_data_s;
  logic [3:0]      tx_valid_s;
  logic [3:0]      tx_ready_s;
  logic [3:0]      tx_s;
  logic [3:0]      busy_s;
  logic [3:0]      tx_done_s;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data_s[0]), .tx_valid(tx_valid_s[0]),
    .tx_ready(tx_ready_s[0]), .tx(tx_s[0]), .busy(busy_s[0]), .tx_done(tx_done_s[0]));

  uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_even (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data_s[1]), .tx_valid(tx_valid_s[1]),
    .tx_ready(tx_ready_s[1]), .tx(tx_s[1]), .busy(busy_s[1]), .tx_done(tx_done_s[1]));

  uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_odd (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data_s[2]), .tx_valid(tx_valid_s[2]),
    .tx_ready(tx_ready_s[2]), .tx(tx_s[2]), .busy(busy_s[2]), .tx_done(tx_done_s[2]));

  uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_7n2 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data_s[3]), .tx_valid(tx_valid_s[3]),
    .tx_ready(tx_ready_s[3]), .tx(tx_s[3]), .busy(busy_s[3]), .tx_done(tx_done_s[3]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called on a falling edge with the instance idle; returns on the falling
  // edge inside the first start-bit cycle.
  task automatic start_frame(input int d, input logic [7:0] data, input bit hold);
    check($sformatf("ready_before d%0d", d), 32'(tx_ready_s[d]), 32'd1);
    tx_data_s[d]  = data;
    tx_valid_s[d] = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) tx_valid_s[d] = 1'b0;
    @(negedge clk);
    check($sformatf("latency_tx d%0d", d), 32'(tx_s[d]), 32'd1);
    check($sformatf("ready_low d%0d", d), 32'(tx_ready_s[d]), 32'd0);
    @(negedge clk);
  endtask

  // Checks every cycle of a frame starting at start-bit cycle 1; returns on
  // the falling edge of the tx_done cycle.
  task automatic expect_frame(input int d, input logic [7:0] data, input int nbits,
                              input bit has_par, input logic par_bit, input int stops);
    int   total;
    int   idx;
    logic exp_bit;
    total = (1 + nbits + int'(has_par) + stops) * CPB;
    for (int k = 1; k <= total; k++) begin
      idx = (k - 1) / CPB;
      if (idx == 0)                          exp_bit = 1'b0;
      else if (idx <= nbits)                 exp_bit = data[idx-1];
      else if (has_par && (idx == nbits + 1)) exp_bit = par_bit;
      else                                   exp_bit = 1'b1;
      check($sformatf("tx d%0d data%0h cyc%0d", d, data, k), 32'(tx_s[d]), 32'(exp_bit));
      check($sformatf("tx_done d%0d data%0h cyc%0d", d, data, k), 32'(tx_done_s[d]), 32'(k == total));
      check($sformatf("busy d%0d cyc%0d", d, k), 32'(busy_s[d]), 32'd1);
      if (k < total) @(negedge clk);
    end
  endtask

  task automatic idle_after(input int d);
    @(negedge clk);
    check($sformatf("idle_tx d%0d", d), 32'(tx_s[d]), 32'd1);
    check($sformatf("idle_ready d%0d", d), 32'(tx_ready_s[d]), 32'd1);
    check($sformatf("idle_busy d%0d", d), 32'(busy_s[d]), 32'd0);
    check($sformatf("idle_done d%0d", d), 32'(tx_done_s[d]), 32'd0);
  endtask

  initial begin
    rst_n      = 1'b0;
    tx_valid_s = 4'b0000;
    tx_data_s  = '0;

    // Reset held: all instances idle with line high
    repeat (3) begin
      @(negedge clk);
      for (int d = 0; d < 4; d++) begin
        check($sformatf("rst_tx d%0d", d), 32'(tx_s[d]), 32'd1);
        check($sformatf("rst_ready d%0d", d), 32'(tx_ready_s[d]), 32'd1);
        check($sformatf("rst_busy d%0d", d), 32'(busy_s[d]), 32'd0);
        check($sformatf("rst_done d%0d", d), 32'(tx_done_s[d]), 32'd0);
      end
    end
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("post_rst_tx", 32'(tx_s[0]), 32'd1);
      check("post_rst_done", 32'(tx_done_s[0]), 32'd0);
    end

    // 8N1 0xA5: 1,0,1,0,0,1,0,1 LSB first, done in cycle 40
    start_frame(0, 8'hA5, 1'b0);
    expect_frame(0, 8'hA5, 8, 1'b0, 1'b0, 1);
    idle_after(0);

    // Back-to-back with valid held: 0x00 then 0xFF, second start at done+2
    @(negedge clk);
    start_frame(0, 8'h00, 1'b1);
    expect_frame(0, 8'h00, 8, 1'b0, 1'b0, 1);
    tx_data_s[0] = 8'hFF;
    @(negedge clk);
    check("b2b_gap_tx", 32'(tx_s[0]), 32'd1);
    check("b2b_gap_ready", 32'(tx_ready_s[0]), 32'd0);
    @(negedge clk);
    check("b2b_second_start", 32'(tx_s[0]), 32'd0);
    tx_valid_s[0] = 1'b0;
    expect_frame(0, 8'hFF, 8, 1'b0, 1'b0, 1);
    idle_after(0);

    // Parity on 0x07: even -> 1, odd -> 0, 44-cycle frames
    start_frame(1, 8'h07, 1'b0);
    expect_frame(1, 8'h07, 8, 1'b1, 1'b1, 1);
    idle_after(1);
    start_frame(2, 8'h07, 1'b0);
    expect_frame(2, 8'h07, 8, 1'b1, 1'b0, 1);
    idle_after(2);

    // 7 data bits, 2 stop bits: bit 7 of the input never reaches the line
    start_frame(3, 8'h7F, 1'b0);
    expect_frame(3, 8'h7F, 7, 1'b0, 1'b0, 2);
    idle_after(3);

    // Reset during data bit 3 of 0x55 (cycles 17..20 of the frame)
    start_frame(0, 8'h55, 1'b0);
    repeat (17) @(negedge clk);
    check("mid_bit3_tx", 32'(tx_s[0]), 32'd0);
    check("mid_bit3_busy", 32'(busy_s[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_tx", 32'(tx_s[0]), 32'd1);
    check("async_rst_ready", 32'(tx_ready_s[0]), 32'd1);
    check("async_rst_busy", 32'(busy_s[0]), 32'd0);
    check("async_rst_done", 32'(tx_done_s[0]), 32'd0);
    repeat (2) begin
      @(negedge clk);
      check("in_rst_tx", 32'(tx_s[0]), 32'd1);
      check("in_rst_done", 32'(tx_done_s[0]), 32'd0);
    end
    rst_n = 1'b1;

    // New byte accepted on the first edge after reset release
    start_frame(0, 8'h3C, 1'b0);
    expect_frame(0, 8'h3C, 8, 1'b0, 1'b0, 1);
    idle_after(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
